lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator between the core's execute stage and the byte-addressed data memory.
- Memory side: 1-cycle registered read and full 4-byte write per access.
- Converts core requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory reads and writes, with lane extraction and sign/zero extension.
- Performs read-modify-write for sub-word stores; faults misaligned, out-of-range and illegal requests without touching memory.

Parameters:
- MEM_BYTES, 512, size of the attached memory in bytes; word-aligned accesses at or above MEM_BYTES-3 fault.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-high (asserted when rst_n=1)
- req_valid_i  input  1  core request valid
- req_ready_o  output  1  block can accept a request (IDLE only)
- req_we_i  input  1  1=store, 0=load
- req_funct3_i  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr_i  input  32  byte address
- req_wdata_i  input  32  store data; low bits used for B/H
- rsp_valid_o  output  1  one-cycle response pulse
- rsp_rdata_o  output  32  extended load data; 0 for stores and faults
- rsp_err_o  output  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
- mem_re_o  output  1  memory read enable
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  32  word-aligned byte address (bits[1:0]=00)
- mem_wdata_o  output  32  full word to write
- mem_rdata_i  input  32  memory read data, valid the cycle after mem_re_o

Behaviour:
- Reset (rst_n=1, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0 except req_ready_o=1 once released.
  - In-flight access is abandoned; a pending RMW write is never issued, and mem_we_o drops immediately.
- Handshake:
  - A request is accepted on the edge where req_valid_i & req_ready_o.
  - The request is latched at accept; inputs are ignored afterwards.
  - req_ready_o=1 only in IDLE.
- Validation at accept, first match wins:
  - Load funct3 not in {000,001,010,100,101}, or store funct3 not in {000,001,010}: illegal (11).
  - H/HU with addr[0]=1, or W with addr[1:0]≠00: misaligned (01).
  - (addr & ~3) > MEM_BYTES-4: out of range (10).
- States:
  - IDLE: on accept go to LD_REQ, ST_WR (SW), RMW_RD (SB/SH), or RESP (fault).
  - LD_REQ: mem_re_o=1, mem_addr_o=addr&~3; go to LD_CAP.
  - LD_CAP: select lane from mem_rdata_i, extend, register into data reg; go to RESP.
    - Byte lane = addr[1:0]; half lane = addr[1].
    - B/H sign-extend; BU/HU zero-extend; W passes through.
  - ST_WR: mem_we_o=1, mem_wdata_o=req_wdata; go to RESP.
  - RMW_RD: mem_re_o=1; go to RMW_MRG.
  - RMW_MRG: merge wdata[7:0] (SB) or wdata[15:0] (SH) into the selected lane of mem_rdata_i; keep other bytes; register the result; go to RMW_WR.
  - RMW_WR: mem_we_o=1, mem_wdata_o=merged word; go to RESP.
  - RESP: rsp_valid_o=1 for exactly one cycle, with rsp_rdata_o and rsp_err_o; go to IDLE.
- Latency, accept edge to rsp_valid_o cycle:
  - fault: 1
  - SW: 2
  - load: 3
  - SB/SH: 4
  - Next accept is possible the cycle after RESP.
- Memory-side rules:
  - mem_re_o and mem_we_o are never high together.
  - Each is high for at most one cycle per request.
  - mem_addr_o, mem_wdata_o and enables are 0 outside active states.
  - A faulted request never asserts mem_re_o or mem_we_o.
- rsp_rdata_o and rsp_err_o hold their value only during rsp_valid_o; they are 0 otherwise.
- Address wrap: aligned address 0xFFFFFFFC with MEM_BYTES=512 gives out of range, with no wrap to 0.

Test Plan:
- Memory word 0x80 = 0x8899AABB; LB at 0x81 → rsp_rdata_o=0xFFFFFFAA, err=00, rsp_valid 3 cycles after accept; LBU at 0x81 → 0x000000AA; LH at 0x82 → 0xFFFF8899.
- SW 0x12345678 at 0x40 → single mem_we_o cycle, mem_addr_o=0x40, mem_wdata_o=0x12345678, rsp 2 cycles after accept; LW at 0x40 → 0x12345678.
- Word 0x40 = 0x12345678; SB 0xEE at 0x42 → one re cycle, then one we cycle writing 0x12EE5678, rsp 4 cycles after accept; SH 0xBEEF at 0x40 → writes 0x12EEBEEF.
- Fault cases, each giving rsp 1 cycle after accept, no memory enables, rdata=0:
  - LW at 0x41 → err=01
  - LH at 0x203 → err=01
  - LW at 0x200 → err=10
  - store with funct3=100 → err=11
- Assert rst_n=1 during RMW_MRG of an SB → mem_we_o stays 0, memory unchanged, rsp_valid_o never pulses; after release, req_ready_o=1 and a new LW succeeds.
- Hold req_valid_i high with 3 back-to-back LWs → each accepted only when req_ready_o=1; mem_re_o never overlaps mem_we_o; responses arrive in order.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if - bundles the core request/response handshake and the
// word-wide data memory port of the load/store unit.
//   req_*  : core -> LSU request (valid/ready handshake, funct3, address, store data)
//   rsp_*  : LSU -> core one-cycle response pulse with load data and error code
//   mem_*  : LSU -> memory word access; mem_rdata_i returns the cycle after mem_re_o
// Modport master is the LSU itself; slave is the environment (core + memory).
interface lsu_mem_master_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;

    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;

    logic        mem_re_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport master (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master - load/store initiator between the execute stage and a
// byte-addressed data memory with a 1-cycle registered read port and
// full-word writes.
//   clk   : clock
//   rst_n : asynchronous reset, active HIGH (asserted while rst_n = 1)
//   bus   : lsu_mem_master_if.master - request/response handshake and memory port
// Loads read the containing word and extract/extend the addressed lane.
// SW writes directly; SB/SH do read-modify-write. Faulting requests answer
// with an error code and never touch memory.
//
// state   | meaning
// IDLE    | ready for a request
// LD_REQ  | load: issue word read
// LD_CAP  | load: capture lane from read data, extend
// ST_WR   | SW: write full word
// RMW_RD  | SB/SH: read containing word
// RMW_MRG | SB/SH: merge store lane into read word
// RMW_WR  | SB/SH: write merged word
// RESP    | one-cycle response to the core
module lsu_mem_master #(
    parameter int unsigned MEM_BYTES = 512
) (
    input logic               clk,
    input logic               rst_n,
    lsu_mem_master_if.master  bus
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_CAP,
        ST_WR,
        RMW_RD,
        RMW_MRG,
        RMW_WR,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  err_q;
    logic [31:0] data_q;

    logic        req_ready;
    logic        accept;
    logic [1:0]  req_err;
    logic [31:0] load_ext;
    logic [31:0] merged;

    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    // First matching fault wins: illegal funct3, then alignment, then range.
    function automatic logic [1:0] check_req(input logic we, input logic [2:0] f3,
                                             input logic [31:0] addr);
        logic illegal;
        logic misaligned;
        if (we)
            illegal = f3[2] | (f3[1:0] == 2'b11);
        else
            illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
        misaligned = ((f3[1:0] == 2'b01) & addr[0]) |
                     ((f3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        if (illegal)
            return ERR_ILL;
        else if (misaligned)
            return ERR_ALIGN;
        else if ({addr[31:2], 2'b00} > LAST_WORD)
            return ERR_RANGE;
        else
            return ERR_OK;
    endfunction

    // Ready is withheld while reset is asserted so nothing is accepted then.
    assign req_ready = (state == IDLE) & ~rst_n;
    assign accept    = bus.req_valid_i & req_ready;
    assign req_err   = check_req(bus.req_we_i, bus.req_funct3_i, bus.req_addr_i);

    // Lane extraction and extension of the word returned by memory.
    always_comb begin
        logic [31:0] shifted;
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        shifted = bus.mem_rdata_i >> {lat_addr[1:0], 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = lat_addr[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        case (lat_f3)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_ext = {24'h000000, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_ext = {16'h0000, lane_h};
            default: load_ext = bus.mem_rdata_i;
        endcase
    end

    // Store lane merged into the word read back for SB/SH.
    always_comb begin
        merged = bus.mem_rdata_i;
        if (lat_f3[1:0] == 2'b00) begin
            case (lat_addr[1:0])
                2'b00:   merged[7:0]   = lat_wdata[7:0];
                2'b01:   merged[15:8]  = lat_wdata[7:0];
                2'b10:   merged[23:16] = lat_wdata[7:0];
                default: merged[31:24] = lat_wdata[7:0];
            endcase
        end else begin
            if (lat_addr[1])
                merged[31:16] = lat_wdata[15:0];
            else
                merged[15:0]  = lat_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 2'b00;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err != ERR_OK)
                        state_nxt = RESP;
                    else if (!bus.req_we_i)
                        state_nxt = LD_REQ;
                    else if (bus.req_funct3_i[1:0] == 2'b10)
                        state_nxt = ST_WR;
                    else
                        state_nxt = RMW_RD;
                end
            end
            LD_REQ: begin
                mem_re    = 1'b1;
                mem_addr  = {lat_addr[31:2], 2'b00};
                state_nxt = LD_CAP;
            end
            LD_CAP: begin
                state_nxt = RESP;
            end
            ST_WR: begin
                mem_we    = 1'b1;
                mem_addr  = {lat_addr[31:2], 2'b00};
                mem_wdata = lat_wdata;
                state_nxt = RESP;
            end
            RMW_RD: begin
                mem_re    = 1'b1;
                mem_addr  = {lat_addr[31:2], 2'b00};
                state_nxt = RMW_MRG;
            end
            RMW_MRG: begin
                state_nxt = RMW_WR;
            end
            RMW_WR: begin
                mem_we    = 1'b1;
                mem_addr  = {lat_addr[31:2], 2'b00};
                mem_wdata = data_q;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                // data_q holds the merged word after an RMW; stores report 0.
                if (!lat_we && err_q == ERR_OK)
                    rsp_rdata = data_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lat_we    <= 1'b0;
            lat_f3    <= 3'b000;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            err_q     <= 2'b00;
            data_q    <= 32'h0;
        end else begin
            if (accept) begin
                lat_we    <= bus.req_we_i;
                lat_f3    <= bus.req_funct3_i;
                lat_addr  <= bus.req_addr_i;
                lat_wdata <= bus.req_wdata_i;
                err_q     <= req_err;
                data_q    <= 32'h0;
            end else if (state == LD_CAP) begin
                data_q <= load_ext;
            end else if (state == RMW_MRG) begin
                data_q <= merged;
            end
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.rsp_err_o   = rsp_err;
    assign bus.mem_re_o    = mem_re;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master - self-checking bench for lsu_mem_master.
// A behavioural 512-byte memory answers the DUT. Each request pushes its
// expected response (data, error code, latency) onto a scoreboard queue; a
// monitor pops and compares whenever rsp_valid_o pulses, and also watches the
// memory-side rules every cycle.
module tb_lsu_mem_master;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          acc;
    } exp_t;

    localparam int NF = 8;
    localparam logic        F_WE   [NF] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [2:0]  F_F3   [NF] = '{3'b010, 3'b001, 3'b010, 3'b100,
                                            3'b010, 3'b011, 3'b001, 3'b101};
    localparam logic [31:0] F_ADDR [NF] = '{32'h41, 32'h203, 32'h200, 32'h40,
                                            32'hFFFFFFFC, 32'h40, 32'h41, 32'h1FF};
    localparam logic [1:0]  F_ERR  [NF] = '{2'b01, 2'b01, 2'b10, 2'b11,
                                            2'b10, 2'b11, 2'b01, 2'b01};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem_master_if bus();

    lsu_mem_master #(.MEM_BYTES(512)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    logic [31:0] mem [0:127];

    always @(posedge clk) begin
        if (bus.mem_we_o) mem[bus.mem_addr_o[8:2]] <= bus.mem_wdata_o;
        if (bus.mem_re_o) bus.mem_rdata_i <= mem[bus.mem_addr_o[8:2]];
    end

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          re_cnt = 0;
    int          we_cnt = 0;
    int          rsp_cnt = 0;
    logic [31:0] last_we_addr = 32'h0;
    logic [31:0] last_we_data = 32'h0;

    task automatic clear_counts();
        re_cnt  = 0;
        we_cnt  = 0;
        rsp_cnt = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_err, input int exp_lat,
                          input bit track, input bit hold, output int acc);
        int   n;
        exp_t e;
        acc = -1;
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        n = 0;
        while (bus.req_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout addr=%h: req_ready_o never seen", addr);
            bus.req_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (track) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = exp_lat;
            e.acc   = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!hold) begin
            // Inputs after accept must be ignored by the DUT.
            bus.req_valid_i  = 1'b0;
            bus.req_we_i     = ~we;
            bus.req_funct3_i = 3'b111;
            bus.req_addr_i   = $urandom;
            bus.req_wdata_i  = $urandom;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses still pending, required 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'b000;
        bus.req_addr_i   = 32'h0;
        bus.req_wdata_i  = 32'h0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.req_ready_o, bus.rsp_valid_o, bus.mem_re_o, bus.mem_we_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: ready/rsp/re/we=%b required 0000",
                     {bus.req_ready_o, bus.rsp_valid_o, bus.mem_re_o, bus.mem_we_o});
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", bus.req_ready_o);
        end
    endtask

    task automatic test_loads();
        int acc;
        clear_counts();
        do_req(1'b1, 3'b010, 32'h80, 32'h8899AABB, 32'h0, 2'b00, 2, 1'b1, 1'b0, acc);
        do_req(1'b0, 3'b000, 32'h81, 32'h0, 32'hFFFFFFAA, 2'b00, 3, 1'b1, 1'b0, acc);
        do_req(1'b0, 3'b100, 32'h81, 32'h0, 32'h000000AA, 2'b00, 3, 1'b1, 1'b0, acc);
        do_req(1'b0, 3'b001, 32'h82, 32'h0, 32'hFFFF8899, 2'b00, 3, 1'b1, 1'b0, acc);
        do_req(1'b0, 3'b101, 32'h82, 32'h0, 32'h00008899, 2'b00, 3, 1'b1, 1'b0, acc);
        do_req(1'b0, 3'b000, 32'h80, 32'h0, 32'hFFFFFFBB, 2'b00, 3, 1'b1, 1'b0, acc);
        do_req(1'b0, 3'b010, 32'h80, 32'h0, 32'h8899AABB, 2'b00, 3, 1'b1, 1'b0, acc);
        wait_drain("loads");
        n_checks++;
        if (re_cnt != 6 || we_cnt != 1) begin
            n_fail++;
            $display("FAIL loads_enables: re=%0d we=%0d required re=6 we=1", re_cnt, we_cnt);
        end
    endtask

    task automatic test_store_word();
        int acc;
        clear_counts();
        do_req(1'b1, 3'b010, 32'h40, 32'h12345678, 32'h0, 2'b00, 2, 1'b1, 1'b0, acc);
        wait_drain("sw");
        n_checks++;
        if (we_cnt != 1 || re_cnt != 0 || last_we_addr !== 32'h40 || last_we_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL sw_write: we=%0d re=%0d addr=%h data=%h required 1 0 00000040 12345678",
                     we_cnt, re_cnt, last_we_addr, last_we_data);
        end
        do_req(1'b0, 3'b010, 32'h40, 32'h0, 32'h12345678, 2'b00, 3, 1'b1, 1'b0, acc);
        wait_drain("lw");
    endtask

    task automatic test_rmw();
        int acc;
        clear_counts();
        do_req(1'b1, 3'b000, 32'h42, 32'hAAAAAAEE, 32'h0, 2'b00, 4, 1'b1, 1'b0, acc);
        wait_drain("sb");
        n_checks++;
        if (re_cnt != 1 || we_cnt != 1 || last_we_addr !== 32'h40 || last_we_data !== 32'h12EE5678) begin
            n_fail++;
            $display("FAIL sb_rmw: re=%0d we=%0d addr=%h data=%h required 1 1 00000040 12EE5678",
                     re_cnt, we_cnt, last_we_addr, last_we_data);
        end
        clear_counts();
        do_req(1'b1, 3'b001, 32'h40, 32'h1234BEEF, 32'h0, 2'b00, 4, 1'b1, 1'b0, acc);
        wait_drain("sh");
        n_checks++;
        if (re_cnt != 1 || we_cnt != 1 || last_we_data !== 32'h12EEBEEF) begin
            n_fail++;
            $display("FAIL sh_rmw: re=%0d we=%0d data=%h required 1 1 12EEBEEF",
                     re_cnt, we_cnt, last_we_data);
        end
        do_req(1'b1, 3'b000, 32'h83, 32'h00000055, 32'h0, 2'b00, 4, 1'b1, 1'b0, acc);
        do_req(1'b0, 3'b101, 32'h42, 32'h0, 32'h000012EE, 2'b00, 3, 1'b1, 1'b0, acc);
        do_req(1'b0, 3'b000, 32'h83, 32'h0, 32'h00000055, 2'b00, 3, 1'b1, 1'b0, acc);
        wait_drain("rmw_readback");
        n_checks++;
        if (mem[32] !== 32'h5599AABB) begin
            n_fail++;
            $display("FAIL sb_lane3_word: got %h required 5599AABB", mem[32]);
        end
    endtask

    task automatic test_boundary();
        int acc;
        do_req(1'b1, 3'b010, 32'h1FC, 32'hCAFEF00D, 32'h0, 2'b00, 2, 1'b1, 1'b0, acc);
        do_req(1'b0, 3'b010, 32'h1FC, 32'h0, 32'hCAFEF00D, 2'b00, 3, 1'b1, 1'b0, acc);
        do_req(1'b0, 3'b000, 32'h1FF, 32'h0, 32'hFFFFFFCA, 2'b00, 3, 1'b1, 1'b0, acc);
        wait_drain("boundary");
    endtask

    task automatic test_faults();
        int acc;
        for (int i = 0; i < NF; i++) begin
            clear_counts();
            do_req(F_WE[i], F_F3[i], F_ADDR[i], 32'hDEADBEEF, 32'h0, F_ERR[i], 1,
                   1'b1, 1'b0, acc);
            wait_drain("fault");
            n_checks++;
            if (re_cnt != 0 || we_cnt != 0) begin
                n_fail++;
                $display("FAIL fault_%0d_enables: re=%0d we=%0d required 0 0", i, re_cnt, we_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        int acc;
        clear_counts();
        do_req(1'b1, 3'b000, 32'h41, 32'h00000077, 32'h0, 2'b00, 4, 1'b0, 1'b0, acc);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_we_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_rmw_now: we=%b ready=%b required 0 0",
                     bus.mem_we_o, bus.req_ready_o);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_rmw_ready: got %b required 1", bus.req_ready_o);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (we_cnt != 0 || rsp_cnt != 0 || re_cnt != 1 || mem[16] !== 32'h12EEBEEF) begin
            n_fail++;
            $display("FAIL reset_mid_rmw: we=%0d rsp=%0d re=%0d word=%h required 0 0 1 12EEBEEF",
                     we_cnt, rsp_cnt, re_cnt, mem[16]);
        end
        do_req(1'b0, 3'b010, 32'h40, 32'h0, 32'h12EEBEEF, 2'b00, 3, 1'b1, 1'b0, acc);
        wait_drain("post_reset_lw");
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        clear_counts();
        do_req(1'b0, 3'b010, 32'h40,  32'h0, 32'h12EEBEEF, 2'b00, 3, 1'b1, 1'b1, a0);
        do_req(1'b0, 3'b010, 32'h80,  32'h0, 32'h5599AABB, 2'b00, 3, 1'b1, 1'b1, a1);
        do_req(1'b0, 3'b010, 32'h1FC, 32'h0, 32'hCAFEF00D, 2'b00, 3, 1'b1, 1'b0, a2);
        wait_drain("b2b");
        n_checks++;
        if (rsp_cnt != 3 || re_cnt != 3 || we_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b_counts: rsp=%0d re=%0d we=%0d required 3 3 0", rsp_cnt, re_cnt, we_cnt);
        end
        n_checks++;
        if (a1 - a0 != 4 || a2 - a1 != 4) begin
            n_fail++;
            $display("FAIL b2b_spacing: gaps %0d %0d required 4 4", a1 - a0, a2 - a1);
        end
    endtask

    initial begin
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (bus.mem_re_o === 1'b1) re_cnt++;
                if (bus.mem_we_o === 1'b1) begin
                    we_cnt++;
                    last_we_addr = bus.mem_addr_o;
                    last_we_data = bus.mem_wdata_o;
                end
                n_checks++;
                if (bus.mem_re_o === 1'b1 && bus.mem_we_o === 1'b1) begin
                    n_fail++;
                    $display("FAIL mem_overlap at cycle %0d: re=1 we=1 required not both", cyc);
                end else if (bus.mem_re_o !== 1'b1 && bus.mem_we_o !== 1'b1 &&
                             (bus.mem_addr_o !== 32'h0 || bus.mem_wdata_o !== 32'h0 ||
                              bus.mem_re_o !== 1'b0 || bus.mem_we_o !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL mem_idle at cycle %0d: addr=%h wdata=%h required 0",
                             cyc, bus.mem_addr_o, bus.mem_wdata_o);
                end
                if (bus.rsp_valid_o === 1'b1) begin
                    rsp_cnt++;
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_rsp at cycle %0d: rdata=%h err=%b",
                                 cyc, bus.rsp_rdata_o, bus.rsp_err_o);
                    end else begin
                        e = sb.pop_front();
                        if (bus.rsp_rdata_o !== e.rdata) begin
                            n_fail++;
                            $display("FAIL rsp_rdata: got %h required %h", bus.rsp_rdata_o, e.rdata);
                        end
                        n_checks++;
                        if (bus.rsp_err_o !== e.err) begin
                            n_fail++;
                            $display("FAIL rsp_err: got %b required %b", bus.rsp_err_o, e.err);
                        end
                        n_checks++;
                        if (cyc - e.acc + 1 != e.lat) begin
                            n_fail++;
                            $display("FAIL rsp_latency: got %0d required %0d", cyc - e.acc + 1, e.lat);
                        end
                    end
                end else begin
                    n_checks++;
                    if (bus.rsp_rdata_o !== 32'h0 || bus.rsp_err_o !== 2'b00 || bus.rsp_valid_o !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rsp_idle at cycle %0d: valid=%b rdata=%h err=%b required 0",
                                 cyc, bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_o);
                    end
                end
            end
        join_none

        test_reset();
        test_store_word();
        test_loads();
        test_rmw();
        test_boundary();
        test_faults();
        test_reset_mid_rmw();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
